// File: rtl/saph_fpu_pkg.sv
// rtl/saph_fpu_pkg.sv - shared types for the FPU issue/collect stage
package saph_fpu_pkg;

  localparam int TAG_W = 5;

  typedef enum logic [1:0] {
    FPU_MODE_ADD = 2'd0,
    FPU_MODE_SUB = 2'd1,
    FPU_MODE_MUL = 2'd2,
    FPU_MODE_DIV = 2'd3
  } saph_fpu_mode_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             err;
  } saph_fpu_rsp_t;

endpackage

// File: rtl/saph_fpu_issue_if.sv
// rtl/saph_fpu_issue_if.sv - shader-core request/response port of the FPU issue stage
interface saph_fpu_issue_if #(
  parameter int TAG_W = saph_fpu_pkg::TAG_W
);
  import saph_fpu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_lhs;
  logic [31:0]      req_rhs;
  saph_fpu_mode_t   req_mode;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_res;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_lhs, req_rhs, req_mode, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_lhs, req_rhs, req_mode, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_tag, rsp_err
  );

endinterface

// File: rtl/saph_sync_fifo.sv
// rtl/saph_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module saph_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count
);
  import saph_fpu_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/saph_fpu_issue.sv
// rtl/saph_fpu_issue.sv - credit-limited FPU issue/collect stage with in-order tagged results
// SAPH_FPU_ORPHAN_CHECK_EN enables the sticky err_orphan flag and its assertion.
module saph_fpu_issue #(
  parameter int TAG_W   = saph_fpu_pkg::TAG_W,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  saph_fpu_issue_if.slave  core,
  output logic             fpu_d_trig,
  output logic [31:0]      fpu_d_lhs,
  output logic [31:0]      fpu_d_rhs,
  output logic [1:0]       fpu_d_mode,
  input  logic             fpu_d_ready,
  input  logic             fpu_q_trig,
  input  logic [31:0]      fpu_q_res,
  input  logic [3:0]       fpu_has_modes,
  output logic             err_orphan
);
  import saph_fpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = TAG_W + 33;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [CW-1:0]    tag_count;
  logic [CW-1:0]    rsp_count;
  logic [CW:0]      occ;
  logic             credit;
  logic             sup;
  logic             tag_empty;
  logic             err_acc;
  logic             bypass;
  logic             tag_push;
  logic             tag_pop;
  logic             orphan;
  logic             rsp_push;
  logic             rsp_pop;
  logic [TAG_W-1:0] head_tag;
  logic [RW-1:0]    rsp_wdata;
  logic [RW-1:0]    rsp_rdata;

  // Credits come back only on the registered counts, so every issued op owns a result slot.
  assign occ       = {1'b0, tag_count} + {1'b0, rsp_count};
  assign credit    = occ < DEPTH_L;
  assign sup       = fpu_has_modes[core.req_mode];
  assign tag_empty = (tag_count == '0);

  assign fpu_d_trig     = !rst && core.req_valid && sup && fpu_d_ready && credit;
  // Unsupported modes wait for the pipe to drain so the error stays in order.
  assign err_acc        = !rst && core.req_valid && !sup && credit && tag_empty;
  assign core.req_ready = fpu_d_trig || err_acc;

  assign fpu_d_lhs  = core.req_lhs;
  assign fpu_d_rhs  = core.req_rhs;
  assign fpu_d_mode = core.req_mode;

  assign bypass   = (LATENCY == 0) && fpu_d_trig && fpu_q_trig && tag_empty;
  assign tag_push = fpu_d_trig && !bypass;
  assign tag_pop  = fpu_q_trig && !tag_empty;
  assign orphan   = fpu_q_trig && tag_empty && !bypass;

  assign rsp_push  = err_acc || tag_pop || bypass;
  assign rsp_wdata = err_acc ? {core.req_tag, 32'h0, 1'b1}
                             : {(bypass ? core.req_tag : head_tag), fpu_q_res, 1'b0};
  assign rsp_pop   = (rsp_count != '0) && core.rsp_ready;

  assign core.rsp_valid = (rsp_count != '0);
  assign {core.rsp_tag, core.rsp_res, core.rsp_err} = rsp_rdata;

  saph_sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (core.req_tag),
    .pop       (tag_pop),
    .pop_data  (head_tag),
    .count     (tag_count)
  );

  saph_sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (rsp_wdata),
    .pop       (rsp_pop),
    .pop_data  (rsp_rdata),
    .count     (rsp_count)
  );

`ifdef SAPH_FPU_ORPHAN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (orphan) begin
      err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!orphan) else $warning("orphaned FPU result dropped");
  end
`else
  assign err_orphan = 1'b0;
`endif

endmodule

// File: tb/tb_saph_fpu_issue.sv
// tb/tb_saph_fpu_issue.sv - directed self-checking bench for saph_fpu_issue
module tb_saph_fpu_issue;
  import saph_fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fpu_d_trig;
  logic [31:0] fpu_d_lhs;
  logic [31:0] fpu_d_rhs;
  logic [1:0]  fpu_d_mode;
  logic        fpu_d_ready;
  logic        fpu_q_trig;
  logic [31:0] fpu_q_res;
  logic [3:0]  fpu_has_modes;
  logic        err_orphan;

  int checks = 0;
  int errors = 0;

  saph_fpu_issue_if #(.TAG_W(5)) bus ();

  saph_fpu_issue #(.TAG_W(5), .DEPTH(4), .LATENCY(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .core          (bus.slave),
    .fpu_d_trig    (fpu_d_trig),
    .fpu_d_lhs     (fpu_d_lhs),
    .fpu_d_rhs     (fpu_d_rhs),
    .fpu_d_mode    (fpu_d_mode),
    .fpu_d_ready   (fpu_d_ready),
    .fpu_q_trig    (fpu_q_trig),
    .fpu_q_res     (fpu_q_res),
    .fpu_has_modes (fpu_has_modes),
    .err_orphan    (err_orphan)
  );

  always #5 clk = ~clk;

  // FPU model: floats mapped through doubles for add/sub, bit ops for the other modes.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'h0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_fn(input logic [31:0] l, input logic [31:0] r,
                                         input logic [1:0] m);
    case (m)
      2'd0:    return r2f(f2r(l) + f2r(r));
      2'd1:    return r2f(f2r(l) - f2r(r));
      2'd2:    return l ^ r;
      default: return {r[15:0], l[15:0]};
    endcase
  endfunction

  int          lat = 0;
  logic        fpu_flush;
  logic        pv [8];
  logic [31:0] pr [8];

  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pv[i] <= fpu_flush ? 1'b0 : pv[i-1];
      pr[i] <= pr[i-1];
    end
    pv[0] <= fpu_flush ? 1'b0 : fpu_d_trig;
    pr[0] <= fpu_fn(fpu_d_lhs, fpu_d_rhs, fpu_d_mode);
  end

  always_comb begin
    fpu_q_trig = fpu_d_trig;
    fpu_q_res  = fpu_fn(fpu_d_lhs, fpu_d_rhs, fpu_d_mode);
    if (lat > 0) begin
      fpu_q_trig = pv[lat-1];
      fpu_q_res  = pr[lat-1];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] l, input logic [31:0] r,
                         input saph_fpu_mode_t m, input logic [4:0] t);
    bus.req_valid = v;
    bus.req_lhs   = l;
    bus.req_rhs   = r;
    bus.req_mode  = m;
    bus.req_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fpu_flush = 1'b1;
    set_req(1'b1, 32'h3F800000, 32'h3F800000, FPU_MODE_ADD, 5'd1);
    fpu_d_ready = 1'b1;
    fpu_has_modes = 4'hF;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    checks++; if (fpu_d_trig !== 1'b0) begin errors++; $display("FAIL reset_d_trig got %b want 0", fpu_d_trig); end
    next_cycle();
    rst = 1'b0;
    fpu_flush = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan got %b want 0", err_orphan); end
  endtask

  task automatic test_bypass();
    lat = 0;
    next_cycle();
    set_req(1'b1, 32'h3F800000, 32'h40000000, FPU_MODE_ADD, 5'd3);
    @(negedge clk);
    checks++; if (fpu_d_trig !== 1'b1) begin errors++; $display("FAIL bypass_trig got %b want 1", fpu_d_trig); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got %b want 1", bus.req_ready); end
    checks++; if (fpu_d_rhs !== 32'h40000000) begin errors++; $display("FAIL bypass_rhs_pass got %h want 40000000", fpu_d_rhs); end
    next_cycle();
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bypass_rsp_valid got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_tag !== 5'd3) begin errors++; $display("FAIL bypass_tag got %0d want 3", bus.rsp_tag); end
    checks++; if (bus.rsp_res !== 32'h40400000) begin errors++; $display("FAIL bypass_res got %h want 40400000", bus.rsp_res); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL bypass_err got %b want 0", bus.rsp_err); end
    next_cycle();
    bus.rsp_ready = 1'b1;
    next_cycle();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bypass_drained got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_credit();
    int trigs = 0;
    int tag = 0;
    int got [$];
    logic [31:0] res4 = 32'h0;
    lat = 3;
    bus.rsp_ready = 1'b0;
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      set_req(1'b1, 32'h3F800000, 32'h40000000 | (32'(tag) << 20), FPU_MODE_ADD, 5'(tag));
      @(negedge clk);
      if (fpu_d_trig) trigs++;
      if (c == 4) begin
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL credit_fifth_blocked got %b want 0", bus.req_ready); end
      end
      if (bus.req_ready) tag++;
      next_cycle();
    end
    checks++; if (trigs != 4) begin errors++; $display("FAIL credit_trig_count got %0d want 4", trigs); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.rsp_tag !== 5'd0 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL credit_first_tag got %0d/%b want 0/1", bus.rsp_tag, bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL credit_pop_cycle_ready got %b want 0", bus.req_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (fpu_d_trig !== 1'b1 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL credit_reissue got %b/%b want 1/1", fpu_d_trig, bus.req_ready); end
    checks++; if (bus.rsp_tag !== 5'd1) begin errors++; $display("FAIL credit_second_tag got %0d want 1", bus.rsp_tag); end
    next_cycle();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got.push_back(int'(bus.rsp_tag));
        if (bus.rsp_tag == 5'd4) res4 = bus.rsp_res;
      end
      next_cycle();
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL credit_drain_count got %0d want 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] != i + 2) begin errors++; $display("FAIL credit_order got %0d want %0d", got[i], i + 2); end
    end
    checks++; if (res4 !== fpu_fn(32'h3F800000, 32'h40400000, 2'd0)) begin errors++; $display("FAIL credit_res4 got %h want %h", res4, fpu_fn(32'h3F800000, 32'h40400000, 2'd0)); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_unsupported();
    int holds = 0;
    logic accepted = 1'b0;
    lat = 2;
    fpu_has_modes = 4'b0011;
    set_req(1'b1, 32'h3F800000, 32'h3F800000, FPU_MODE_ADD, 5'd6);
    @(negedge clk);
    checks++; if (fpu_d_trig !== 1'b1) begin errors++; $display("FAIL unsup_first_trig got %b want 1", fpu_d_trig); end
    next_cycle();
    set_req(1'b1, 32'h12345678, 32'h9ABCDEF0, FPU_MODE_MUL, 5'd7);
    for (int k = 0; k < 10 && !accepted; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        accepted = 1'b1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd6) begin errors++; $display("FAIL unsup_prior_done got %b/%0d want 1/6", bus.rsp_valid, bus.rsp_tag); end
      end else begin
        holds++;
      end
      checks++; if (fpu_d_trig !== 1'b0) begin errors++; $display("FAIL unsup_no_trig got %b want 0", fpu_d_trig); end
      next_cycle();
    end
    checks++; if (accepted !== 1'b1 || holds != 2) begin errors++; $display("FAIL unsup_hold got %b/%0d want 1/2", accepted, holds); end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.rsp_tag !== 5'd6 || bus.rsp_err !== 1'b0 || bus.rsp_res !== 32'h40000000) begin errors++; $display("FAIL unsup_rsp6 got %0d/%b/%h want 6/0/40000000", bus.rsp_tag, bus.rsp_err, bus.rsp_res); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd7 || bus.rsp_err !== 1'b1 || bus.rsp_res !== 32'h0) begin errors++; $display("FAIL unsup_rsp7 got %b/%0d/%b/%h want 1/7/1/0", bus.rsp_valid, bus.rsp_tag, bus.rsp_err, bus.rsp_res); end
    next_cycle();
    bus.rsp_ready = 1'b0;
    fpu_has_modes = 4'hF;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL unsup_drained got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_dready();
    logic found = 1'b0;
    lat = 1;
    fpu_d_ready = 1'b0;
    next_cycle();
    set_req(1'b1, 32'h40000000, 32'h40000000, FPU_MODE_ADD, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (fpu_d_trig !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL dready_stall got %b/%b want 0/0", fpu_d_trig, bus.req_ready); end
      next_cycle();
    end
    fpu_d_ready = 1'b1;
    @(negedge clk);
    checks++; if (fpu_d_trig !== 1'b1 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL dready_issue got %b/%b want 1/1", fpu_d_trig, bus.req_ready); end
    next_cycle();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        found = 1'b1;
        checks++; if (bus.rsp_tag !== 5'd9 || bus.rsp_res !== 32'h40800000) begin errors++; $display("FAIL dready_rsp got %0d/%h want 9/40800000", bus.rsp_tag, bus.rsp_res); end
      end
      next_cycle();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL dready_timeout got %b want 1", found); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_inflight();
    logic saw = 1'b0;
    logic exp_orphan;
`ifdef SAPH_FPU_ORPHAN_CHECK_EN
    exp_orphan = 1'b1;
`else
    exp_orphan = 1'b0;
`endif
    lat = 4;
    bus.rsp_ready = 1'b0;
    next_cycle();
    for (int t = 10; t < 12; t++) begin
      set_req(1'b1, 32'h3F800000, 32'h3F800000, FPU_MODE_SUB, 5'(t));
      @(negedge clk);
      checks++; if (fpu_d_trig !== 1'b1) begin errors++; $display("FAIL rstflight_issue got %b want 1", fpu_d_trig); end
      next_cycle();
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstflight_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (dut.occ !== 4'd0) begin errors++; $display("FAIL rstflight_occ got %0d want 0", dut.occ); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
      next_cycle();
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstflight_stray_rsp got %b want 0", saw); end
    checks++; if (err_orphan !== exp_orphan) begin errors++; $display("FAIL rstflight_orphan got %b want %b", err_orphan, exp_orphan); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rstflight_orphan_clear got %b want 0", err_orphan); end
  endtask

  task automatic test_back_to_back();
    saph_fpu_rsp_t exp_q [$];
    saph_fpu_rsp_t e;
    int sent = 0;
    int got = 0;
    int stalls = 0;
    lat = 1;
    bus.rsp_ready = 1'b1;
    next_cycle();
    for (int c = 0; c < 400 && got < 100; c++) begin
      if (sent < 100) begin
        set_req(1'b1,
                {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)},
                {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)},
                saph_fpu_mode_t'($urandom_range(0, 3)), 5'(sent));
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.rsp_valid) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_unexpected got tag %0d want none", bus.rsp_tag);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_tag !== e.tag || bus.rsp_res !== e.res || bus.rsp_err !== e.err) begin
            errors++; $display("FAIL stream_rsp got %0d/%h/%b want %0d/%h/%b", bus.rsp_tag, bus.rsp_res, bus.rsp_err, e.tag, e.res, e.err);
          end
        end
      end
      if (bus.req_valid) begin
        if (bus.req_ready) begin
          exp_q.push_back('{tag: bus.req_tag, res: fpu_fn(bus.req_lhs, bus.req_rhs, bus.req_mode), err: 1'b0});
          sent++;
        end else begin
          stalls++;
        end
      end
      next_cycle();
    end
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count got %0d want 100", got); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL stream_stalls got %0d want 0", stalls); end
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_credit();
    test_unsupported();
    test_dready();
    test_reset_inflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/saph_fpu_issue.md
Name: saph_fpu_issue

Overview:
- GPU-side issue/collect stage that sits directly upstream of the FPU interface.
- Accepts tagged FPU requests from the shader core and drives the FPU through its GPU-side signals (d_trig, d_lhs, d_rhs, d_mode, d_ready, q_trig, q_res, has_modes).
- Tracks in-flight tags in order and returns tagged results through a backpressured response port.
- The FPU cannot be stalled, so issue is credit-limited so that every result always has a buffer slot.

Parameters:
- TAG_W, 5, width of request/response tag.
- DEPTH, 4, max in-flight plus buffered results; both internal FIFOs have this depth; power of two ≥ 2.
- LATENCY, 0, FPU latency from d_trig to q_trig, matching the interface latency; 0 = same cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_lhs  in  32  left operand (float).
- req_rhs  in  32  right operand (float).
- req_mode  in  2  FPU mode.
- req_tag  in  TAG_W  destination tag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_res  out  32  result (float).
- rsp_tag  out  TAG_W  tag of the result.
- rsp_err  out  1  mode unsupported; rsp_res = 0.
- fpu_d_trig  out  1  FPU trigger.
- fpu_d_lhs  out  32  FPU lhs.
- fpu_d_rhs  out  32  FPU rhs.
- fpu_d_mode  out  2  FPU mode.
- fpu_d_ready  in  1  FPU ready.
- fpu_q_trig  in  1  FPU result valid.
- fpu_q_res  in  32  FPU result.
- fpu_has_modes  in  4  supported-mode mask.
- err_orphan  out  1  sticky: result arrived with no tag outstanding.

Behaviour:
- Reset: both FIFOs empty; err_orphan = 0; rsp_valid = 0. While rst = 1, req_ready = 0 and fpu_d_trig = 0.
- Definitions: sup = fpu_has_modes[req_mode]; occ = tag_count + rsp_count (registered, no same-cycle credit return); credit = occ < DEPTH.
- Supported mode:
  - fpu_d_trig = req_valid & sup & fpu_d_ready & credit.
  - req_ready = fpu_d_trig.
  - fpu_d_lhs/rhs/mode are combinational passthrough of req_*.
- Unsupported mode:
  - req_ready = req_valid & credit & (tag_count == 0), so responses stay in order.
  - On accept, push {req_tag, 0, err = 1} into the result FIFO; the FPU is never triggered.
- Tag FIFO: push req_tag on fpu_d_trig; pop on fpu_q_trig. Push and pop in the same cycle leave the count unchanged.
- On fpu_q_trig, push {head tag, fpu_q_res, err = 0} into the result FIFO. Ordering is strict FIFO; the FPU returns results in issue order.
- LATENCY = 0 bypass: fpu_q_trig in the same cycle as fpu_d_trig with the tag FIFO empty uses req_tag directly; no tag push or pop.
- An error push and a q_trig push cannot coincide, because errors require tag_count == 0.
- Result FIFO is first-word-fall-through: rsp_valid = non-empty; pop on rsp_valid & rsp_ready.
- Throughput: one op per cycle is sustained when DEPTH ≥ LATENCY + 2 and rsp_ready = 1.
- Full: with occ == DEPTH, req_ready = 0 and no trigger.
- Empty: rsp_valid = 0.
- Orphan result: fpu_q_trig with the tag FIFO empty and no bypass means the result is dropped.
- Pointers are log2(DEPTH) bits and wrap naturally; counts are log2(DEPTH)+1 bits.
- Reset mid-operation discards all in-flight and buffered state. The FPU shares rst; stray q_trig after reset is treated as orphaned.

Optional Feature:
- SAPH_FPU_ORPHAN_CHECK_EN defined: err_orphan is set on any orphaned q_trig and cleared only by rst. A simulation assertion also fires.
- Not defined: err_orphan is tied to 0; orphaned results are silently dropped.

Decomposition:
- saph_fpu_pkg: saph_fpu_mode_t (2-bit mode encoding) and saph_fpu_rsp_t struct {tag, res, err}. TAG_W is the package default.
- Sub-module saph_sync_fifo (parameterised width/depth, FWFT, count output), instantiated twice: tag FIFO and result FIFO.

Test Plan:
- LATENCY=0, has_modes=4'hF: req lhs=0x3F800000, rhs=0x40000000, mode 0, tag 3; FPU model returns 0x40400000 same cycle -> rsp_valid next cycle, rsp_tag=3, rsp_res=0x40400000, rsp_err=0.
- LATENCY=3, DEPTH=4, rsp_ready=0: issue 5 back-to-back -> exactly 4 triggers, req_ready=0 on the 5th. Then assert rsp_ready -> tags 0..3 emerge in order; 5th issues one cycle after the first pop.
- has_modes=4'b0011, mode 2 (tag 7) sent right behind mode 0 (tag 6) with LATENCY=2 -> tag 7 held until tag 6 returns. Then rsp_tag=6/err=0, followed by rsp_tag=7, err=1, res=0.
- fpu_d_ready low for 3 cycles with req_valid high -> no trigger and req_ready=0 those cycles; issue on the first ready cycle.
- Assert rst with 2 in flight (LATENCY=4) -> next cycle rsp_valid=0 and occ=0. A late q_trig sets err_orphan=1 with the macro, 0 without, and no response.
- LATENCY=1, DEPTH=4, rsp_ready=1: 100 random supported ops -> 100 responses, in order, values match the model, no stall cycles.
